// File: rtl/nibble_serial_add_sub_pkg.sv
// Shared constants and types for the nibble-serial add/sub datapath.
package nibble_alu_pkg;
  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/nibble_serial_add_sub_if.sv
// Request/result handshake bundle; slave is the add/sub block, master drives requests.
interface nibble_serial_add_sub_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, result, carry_out, overflow
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, result, carry_out, overflow
  );
endinterface

// File: rtl/nibble_serial_add_sub_slice.sv
// Combinational 4-bit ripple-carry adder slice.
module nibble_add_slice
  import nibble_alu_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);
  logic [NIBBLE_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[NIBBLE_W];
endmodule

// File: rtl/nibble_serial_add_sub.sv
// WIDTH-bit add/sub streamed LSB nibble first through one 4-bit slice, carry registered between nibbles.
module nibble_serial_add_sub
  import nibble_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  nibble_serial_add_sub_if.slave  bus
);
  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q;
  logic [WIDTH-1:0]   a_q, beff_q, result_q;
  logic               carry_q, carry_out_q, overflow_q;
  logic               out_valid_q, in_ready_q;

  logic [NIBBLE_W-1:0] a_nib, b_nib, sum_nib;
  logic                cout;
  logic                accept, last;

  assign accept = (state_q == IDLE) && in_ready_q && bus.in_valid;
  assign last   = (idx_q == LAST_IDX);

  // b is stored already inverted for subtraction, so the slice only ever adds.
  assign a_nib = a_q[NIBBLE_W*int'(idx_q) +: NIBBLE_W];
  assign b_nib = beff_q[NIBBLE_W*int'(idx_q) +: NIBBLE_W];

  nibble_add_slice u_slice (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry_q),
    .sum  (sum_nib),
    .cout (cout)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    if (out_valid_q && bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      beff_q      <= '0;
      carry_q     <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
      if (accept) begin
        a_q     <= bus.a;
        beff_q  <= bus.b ^ {WIDTH{bus.sub}};
        carry_q <= bus.sub;
        idx_q   <= '0;
      end
      if (state_q == RUN) begin
        result_q[NIBBLE_W*int'(idx_q) +: NIBBLE_W] <= sum_nib;
        carry_q <= cout;
        idx_q   <= idx_q + 1'b1;
        // Flags frozen on the last nibble; sum_nib[MSB] is the result sign bit here.
        if (last) begin
          carry_out_q <= cout;
          overflow_q  <= (a_q[WIDTH-1] == beff_q[WIDTH-1]) &&
                         (sum_nib[NIBBLE_W-1] != a_q[WIDTH-1]);
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.carry_out = carry_out_q;
  assign bus.overflow  = overflow_q;
endmodule
